// File: rtl/uart_rx_module.sv
// 8N1 UART receiver feeding a small circular byte FIFO. The N oldest bytes are exposed in
// parallel, and up to N of them can be popped per cycle.
module uart_rx_module #(
  parameter int unsigned boadrate = 115200,
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned N        = 4
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     rx,
  output logic [N-1:0][7:0]        data,
  input  logic [$clog2(N+1)-1:0]   pop,
  output logic [$clog2(N+1)-1:0]   can_pop
);

  localparam int unsigned BitCycles = CLK_FREQ / boadrate;
  localparam int unsigned TimerW    = $clog2(BitCycles + 1);
  localparam int unsigned PopW      = $clog2(N + 1);
  localparam int unsigned CntW      = $clog2(DEPTH + 1);
  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Timer counts down to zero, so load one less than the wanted interval.
  localparam logic [TimerW-1:0] HalfLoad = TimerW'(BitCycles / 2 - 1);
  localparam logic [TimerW-1:0] FullLoad = TimerW'(BitCycles - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} rx_state_e;

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e         state_q;
  logic [TimerW-1:0] timer_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              push_q;
  logic              timer_done;

  assign timer_done = (timer_q == '0);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            state_q <= StStart;
            timer_q <= HalfLoad;
          end
        end
        StStart: begin
          if (timer_done) begin
            if (rx_sync_q) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_idx_q <= 3'd0;
              timer_q   <= FullLoad;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StData: begin
          if (timer_done) begin
            shift_q[bit_idx_q] <= rx_sync_q;
            timer_q            <= FullLoad;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StStop: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          if (timer_done) begin
            if (rx_sync_q) begin
              push_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              state_q <= StWaitIdle;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        StWaitIdle: begin
          if (rx_sync_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [PopW-1:0]       can_pop_q, can_pop_d;
  logic [N-1:0][7:0]     data_q, data_d;

  // Pops are applied before the push so a full FIFO popped in the push cycle still accepts it.
  always_comb begin
    int unsigned popped, cnt_after, rd, wr, idx;
    mem_d     = mem_q;
    popped    = (32'(pop) < 32'(can_pop_q)) ? 32'(pop) : 32'(can_pop_q);
    cnt_after = 32'(count_q) - popped;
    rd        = (32'(rptr_q) + popped) % DEPTH;
    wr        = (rd + cnt_after) % DEPTH;
    if (push_q && (cnt_after < DEPTH)) begin
      mem_d[PtrW'(wr)] = shift_q;
      cnt_after        = cnt_after + 1;
    end
    count_d   = CntW'(cnt_after);
    rptr_d    = PtrW'(rd);
    can_pop_d = PopW'((cnt_after < N) ? cnt_after : N);
    for (int unsigned i = 0; i < N; i++) begin
      idx       = (rd + i) % DEPTH;
      data_d[i] = (i < cnt_after) ? mem_d[PtrW'(idx)] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      mem_q     <= '0;
      count_q   <= '0;
      rptr_q    <= '0;
      can_pop_q <= '0;
      data_q    <= '0;
    end else begin
      mem_q     <= mem_d;
      count_q   <= count_d;
      rptr_q    <= rptr_d;
      can_pop_q <= can_pop_d;
      data_q    <= data_d;
    end
  end

  assign data    = data_q;
  assign can_pop = can_pop_q;

endmodule

// File: tb/tb_uart_rx_module.sv
// Self-checking bench for uart_rx_module: serial frames are driven on rx while a queue
// holds the FIFO contents the receiver is expected to present.
module tb_uart_rx_module;

  localparam int unsigned Baud    = 115200;
  localparam int unsigned ClkFreq = 1_843_200;
  localparam int unsigned BitCyc  = ClkFreq / Baud;
  localparam int unsigned Depth   = 4;
  localparam int unsigned NWin    = 4;

  logic                 clk = 1'b0;
  logic                 arstn;
  logic                 rx;
  logic [NWin-1:0][7:0] data;
  logic [2:0]           pop;
  logic [2:0]           can_pop;

  int        n_checks = 0;
  int        n_errors = 0;
  logic [7:0] sb_q[$];

  uart_rx_module #(
    .boadrate(Baud),
    .CLK_FREQ(ClkFreq),
    .DEPTH   (Depth),
    .N       (NWin)
  ) dut (
    .clk    (clk),
    .arstn  (arstn),
    .rx     (rx),
    .data   (data),
    .pop    (pop),
    .can_pop(can_pop)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    int unsigned sz = sb_q.size();
    check_eq({tag, " can_pop"}, 32'(can_pop), (sz < NWin) ? sz : NWin);
    for (int i = 0; i < NWin; i++) begin
      check_eq($sformatf("%s data[%0d]", tag, i), 32'(data[i]),
               (i < sz) ? 32'(sb_q[i]) : 32'h0);
    end
  endtask

  task automatic expect_push(input logic [7:0] b);
    if (sb_q.size() < Depth) sb_q.push_back(b);
  endtask

  // Called on a falling edge; returns on a falling edge with the line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BitCyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BitCyc) @(negedge clk);
    end
    rx = stop;
    repeat (BitCyc) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic do_pop(input int unsigned k);
    pop = 3'(k);
    @(negedge clk);
    pop = 3'd0;
    for (int unsigned i = 0; i < k; i++) begin
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int pulses;
    logic [7:0] frames[4];
    frames[0] = 8'h55;
    frames[1] = 8'hF0;
    frames[2] = 8'hF0;
    frames[3] = 8'hF0;

    arstn = 1'b0;
    rx    = 1'b1;
    pop   = 3'd0;
    repeat (3) @(negedge clk);
    check_fifo("reset");
    arstn = 1'b1;
    repeat (50) @(negedge clk);
    check_fifo("idle after reset");

    // Single frame
    expect_push(8'h55);
    send_frame(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    check_fifo("single");
    do_pop(4);
    check_fifo("single drained");

    // Back-to-back frames, then partial and clamped pops
    for (int i = 0; i < 4; i++) begin
      expect_push(frames[i]);
      send_frame(frames[i], 1'b1);
    end
    repeat (10) @(negedge clk);
    check_fifo("b2b");
    do_pop(2);
    check_fifo("pop2");
    do_pop(4);
    check_fifo("pop4 clamped");

    // Pop held at N: each byte appears for exactly one cycle
    pulses = 0;
    pop    = 3'd4;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          sb_q.push_back(frames[i]);
          send_frame(frames[i], 1'b1);
        end
      end
      begin
        repeat (4 * 10 * BitCyc + 30) begin
          @(negedge clk);
          if (can_pop != 3'd0) begin
            pulses++;
            check_eq("stream can_pop", 32'(can_pop), 32'd1);
            if (sb_q.size() == 0) begin
              check_eq("stream unexpected byte", 32'(data[0]), 32'h100);
            end else begin
              check_eq("stream data[0]", 32'(data[0]), 32'(sb_q.pop_front()));
            end
          end
        end
      end
    join
    pop = 3'd0;
    check_eq("stream pulses", 32'(pulses), 32'd4);
    check_eq("stream leftover", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    check_fifo("stream end");

    // Overflow: the fifth byte is dropped
    expect_push(8'h11); send_frame(8'h11, 1'b1);
    expect_push(8'h22); send_frame(8'h22, 1'b1);
    expect_push(8'h33); send_frame(8'h33, 1'b1);
    expect_push(8'h44); send_frame(8'h44, 1'b1);
    expect_push(8'h99); send_frame(8'h99, 1'b1);
    repeat (10) @(negedge clk);
    check_fifo("overflow");

    // Full FIFO with pop=1 in the exact push cycle: push is accepted
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (10 * BitCyc - 5) @(negedge clk);
        pop = 3'd1;
        @(negedge clk);
        pop = 3'd0;
      end
    join
    void'(sb_q.pop_front());
    sb_q.push_back(8'hA5);
    repeat (10) @(negedge clk);
    check_fifo("pop during push");
    do_pop(4);
    check_fifo("drained");

    // One-cycle glitch must not start a frame
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * BitCyc) @(negedge clk);
    check_fifo("glitch");

    // Framing error discards the byte; the next frame is fine
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check_fifo("framing error");
    expect_push(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (10) @(negedge clk);
    check_fifo("after framing error");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
